// File: rtl/fifo_pkg.sv
// Shared defaults and pointer arithmetic for the circular-FIFO pointer controller.
package fifo_pkg;

  localparam int unsigned FIFO_W_DEFAULT  = 2;
  localparam int unsigned FIFO_AF_DEFAULT = 3;
  localparam int unsigned FIFO_AE_DEFAULT = 1;

  // Increment a pointer of 'bits' width, wrapping modulo 2**bits.
  function automatic logic [31:0] ptr_wrap_inc(input logic [31:0] ptr, input logic inc,
                                               input int unsigned bits);
    logic [31:0] mask;
    mask = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    return (ptr + {31'd0, inc}) & mask;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable; also exposes its next-state value.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] ptr_next
);

  always_comb begin
    ptr_next = PW'(ptr_wrap_inc(32'(ptr), inc, PW));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Write/read pointer controller for a reg_file-backed circular FIFO with registered status.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned W        = FIFO_W_DEFAULT,
  parameter int unsigned AF_LEVEL = FIFO_AF_DEFAULT,
  parameter int unsigned AE_LEVEL = FIFO_AE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic         overflow,
  output logic         underflow
`endif
);

  localparam int unsigned PW     = W + 1;
  localparam logic [W:0]  AF_THR = (W+1)'(AF_LEVEL);
  localparam logic [W:0]  AE_THR = (W+1)'(AE_LEVEL);

  logic       push_ok, pop_ok;
  logic [W:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [W:0] count_d, count_q;
  logic       full_q, empty_q, af_q, ae_q;

  // A push into a full FIFO is accepted only if a pop frees the slot on the same edge.
  always_comb begin
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;
    count_d = wr_ptr_next - rd_ptr_next;
  end

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (push_ok),
    .ptr      (wr_ptr),
    .ptr_next (wr_ptr_next)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pop_ok),
    .ptr      (rd_ptr),
    .ptr_next (rd_ptr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      empty_q <= (wr_ptr_next == rd_ptr_next);
      full_q  <= (wr_ptr_next[W] != rd_ptr_next[W]) &&
                 (wr_ptr_next[W-1:0] == rd_ptr_next[W-1:0]);
      af_q    <= (count_d >= AF_THR);
      ae_q    <= (count_d <= AE_THR);
    end
  end

  assign wr_en        = push_ok;
  assign w_addr       = wr_ptr[W-1:0];
  assign r_addr       = rd_ptr[W-1:0];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr & full_q & ~rd);
      unf_q <= unf_q | (rd & empty_q);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule
